// File: rtl/board_status_pkg.sv
// Shared types and helpers for the board status controller.
package board_status_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PULSE = 2'b11
    } led_mode_e;

    // Out-of-range blink selectors pin to the slowest prescaler bit.
    function automatic logic [31:0] clamp_sel(input logic [31:0] sel, input int unsigned width);
        return (sel >= width) ? 32'(width - 1) : sel;
    endfunction

endpackage

// File: rtl/board_status_ctrl_rst_stretch.sv
// Reset conditioner: 2-flop release synchroniser followed by a hold counter
// that keeps the system in reset for HOLD_CYCLES extra edges.
module rst_stretch #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_no
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          rst_n_q, rst_n_d;

    always_comb begin
        sync_d  = {sync_q[0], 1'b1};
        hold_d  = hold_q;
        rst_n_d = rst_n_q;
        if (sync_q[1]) begin
            if (hold_q != CW'(HOLD_CYCLES)) begin
                hold_d = hold_q + CW'(1);
            end else begin
                rst_n_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            hold_q  <= '0;
            rst_n_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hold_q  <= hold_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign rst_no = rst_n_q;

endmodule

// File: rtl/board_status_ctrl.sv
// Board status block: conditioned system reset, per-channel LED modes
// (off/on/blink/event-pulse) and a sticky program-exit display.
module board_status_ctrl
    import board_status_pkg::*;
#(
    parameter int NUM_LEDS        = 4,
    parameter int CNT_WIDTH       = 27,
    parameter int SEL_W           = 5,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int PULSE_CYCLES    = 1000000,
    parameter int FAIL_BIT        = 22
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      rst_no,
    input  logic [2*NUM_LEDS-1:0]     led_mode_i,
    input  logic [SEL_W*NUM_LEDS-1:0] blink_sel_i,
    input  logic [NUM_LEDS-1:0]       event_i,
    input  logic                      exit_valid_i,
    input  logic [31:0]               exit_value_i,
    output logic                      exit_latched_o,
    output logic [NUM_LEDS-1:0]       led_o
);

    localparam int PW    = $clog2(PULSE_CYCLES + 1);
    localparam int IDX_W = (CNT_WIDTH > 1) ? $clog2(CNT_WIDTH) : 1;

    logic run;

    rst_stretch #(
        .HOLD_CYCLES(RST_HOLD_CYCLES)
    ) u_rst_stretch (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rst_no(run)
    );

    assign rst_no = run;

    logic [CNT_WIDTH-1:0] presc_q, presc_d;
    logic [NUM_LEDS-1:0]  event_q, event_d;
    logic [NUM_LEDS-1:0]  chan_led;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 exit_latched_q, exit_latched_d;
    logic                 exit_pass_q, exit_pass_d;

    assign presc_d = run ? presc_q + CNT_WIDTH'(1) : '0;
    assign event_d = run ? event_i : '0;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic             rise;
        logic [PW-1:0]    cnt_q, cnt_d;
        logic [IDX_W-1:0] sel;
        led_mode_e        mode;
        logic             led_ch;

        assign rise = event_i[i] & ~event_q[i];
        assign sel  = IDX_W'(clamp_sel(32'(blink_sel_i[SEL_W*i +: SEL_W]), CNT_WIDTH));
        assign mode = led_mode_e'(led_mode_i[2*i +: 2]);

        // Counters run regardless of mode so a pulse in flight shows on a mode switch.
        always_comb begin
            cnt_d = cnt_q;
            if (!run) begin
                cnt_d = '0;
            end else if (rise) begin
                cnt_d = PW'(PULSE_CYCLES);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - PW'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            led_ch = 1'b0;
            case (mode)
                LED_OFF:   led_ch = 1'b0;
                LED_ON:    led_ch = 1'b1;
                LED_BLINK: led_ch = presc_q[sel];
                LED_PULSE: led_ch = (cnt_q != '0);
                default:   led_ch = 1'b0;
            endcase
        end

        assign chan_led[i] = led_ch;
    end

    always_comb begin
        exit_latched_d = exit_latched_q;
        exit_pass_d    = exit_pass_q;
        if (!run) begin
            exit_latched_d = 1'b0;
            exit_pass_d    = 1'b0;
        end else if (exit_valid_i && !exit_latched_q) begin
            exit_latched_d = 1'b1;
            exit_pass_d    = (exit_value_i == 32'd0);
        end
    end

    always_comb begin
        led_d = chan_led;
        if (!run) begin
            led_d = '0;
        end else if (exit_latched_q) begin
            led_d = exit_pass_q ? '1 : {NUM_LEDS{presc_q[FAIL_BIT]}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q        <= '0;
            event_q        <= '0;
            led_q          <= '0;
            exit_latched_q <= 1'b0;
            exit_pass_q    <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            event_q        <= event_d;
            led_q          <= led_d;
            exit_latched_q <= exit_latched_d;
            exit_pass_q    <= exit_pass_d;
        end
    end

    assign led_o          = led_q;
    assign exit_latched_o = exit_latched_q;

endmodule

// File: tb/tb_board_status_ctrl.sv
// Directed bench for board_status_ctrl with small parameters.
module tb_board_status_ctrl;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int SW = 5;
    localparam int HOLD = 4;
    localparam int FB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_no;
    logic [7:0]    mode;
    logic [19:0]   sel;
    logic [3:0]    evt;
    logic          exit_valid;
    logic [31:0]   exit_val;
    logic          exit_latched;
    logic [3:0]    led;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int rel_edge = 0;

    typedef struct {
        logic [7:0]  mode;
        logic [19:0] sel;
        logic [3:0]  evt;
        logic [3:0]  exp;
    } vec_t;

    vec_t tv[$];

    board_status_ctrl #(
        .NUM_LEDS(NL), .CNT_WIDTH(CW), .SEL_W(SW),
        .RST_HOLD_CYCLES(HOLD), .PULSE_CYCLES(3), .FAIL_BIT(FB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rst_no(rst_no),
        .led_mode_i(mode), .blink_sel_i(sel), .event_i(evt),
        .exit_valid_i(exit_valid), .exit_value_i(exit_val),
        .exit_latched_o(exit_latched), .led_o(led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, ecnt);
        end
    endtask

    // Prescaler value after edge e: zero on the edge rst_no rises, +1 per edge after.
    function automatic logic pbit(input int e, input int b);
        logic [7:0] p;
        p = 8'(e - rel_edge - (HOLD + 3));
        return p[b];
    endfunction

    function automatic int clampv(input int s);
        return (s >= CW) ? CW - 1 : s;
    endfunction

    task automatic release_rst();
        rst = 1'b0;
        rel_edge = ecnt;
        repeat (HOLD + 2) begin
            step();
            chk("rst_hold", rst_no, 1'b0);
        end
        step();
        chk("rst_rise", rst_no, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) step();
        chk("rst_rstno", rst_no, 1'b0);
        chk("rst_led", led, 4'h0);
        chk("rst_latched", exit_latched, 1'b0);
        release_rst();
    endtask

    function automatic void add(input logic [7:0] m, input logic [19:0] s,
                                input logic [3:0] e, input logic [3:0] x);
        vec_t v;
        v.mode = m; v.sel = s; v.evt = e; v.exp = x;
        tv.push_back(v);
    endfunction

    initial begin
        logic [3:0] e;
        rst = 1'b1; mode = '0; sel = '0; evt = '0; exit_valid = 1'b0; exit_val = '0;

        do_reset();

        // Reset re-asserted mid-hold restarts the whole sequence.
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        repeat (4) begin
            step();
            chk("midhold_pre", rst_no, 1'b0);
        end
        rst = 1'b1;
        step();
        chk("midhold_rst", rst_no, 1'b0);
        release_rst();

        add(8'hE4, 20'h0, 4'h0, 4'b0010);
        add(8'hE4, 20'h0, 4'h0, 4'b0010);
        add(8'hE4, 20'h0, 4'h8, 4'b0010);
        add(8'hE4, 20'h0, 4'h0, 4'b1010);
        add(8'hE4, 20'h0, 4'h8, 4'b1010);
        add(8'hE4, 20'h0, 4'h0, 4'b1010);
        add(8'hE4, 20'h0, 4'h0, 4'b1010);
        add(8'hE4, 20'h0, 4'h0, 4'b1010);
        add(8'hE4, 20'h0, 4'h0, 4'b0010);
        add(8'hFF, 20'h0, 4'h0, 4'b0000);
        add(8'h00, 20'h0, 4'h1, 4'b0000);
        add(8'h03, 20'h0, 4'h0, 4'b0001);
        add(8'h03, 20'h0, 4'h0, 4'b0001);
        add(8'h03, 20'h0, 4'h0, 4'b0001);
        add(8'h03, 20'h0, 4'h0, 4'b0000);
        add(8'h20, 20'h07C00, 4'h0, 4'b0000);
        add(8'h20, 20'h07C00, 4'h0, 4'b0000);
        add(8'h28, 20'h07C60, 4'h0, 4'b0000);
        add(8'h28, 20'h07C60, 4'h0, 4'b0000);

        for (int k = 0; k < tv.size(); k++) begin
            mode = tv[k].mode; sel = tv[k].sel; evt = tv[k].evt;
            step();
            e = tv[k].exp;
            for (int c = 0; c < NL; c++) begin
                if (tv[k].mode[2*c +: 2] == 2'b10)
                    e[c] = pbit(ecnt - 1, clampv(int'(tv[k].sel[SW*c +: SW])));
            end
            chk($sformatf("vec%0d", k), led, e);
        end

        // Level held high gives a single pulse.
        mode = 8'hFF; sel = '0; evt = 4'b0100;
        step();
        chk("held_first", led, 4'b0000);
        for (int k = 0; k < 19; k++) begin
            step();
            chk($sformatf("held%0d", k), led, (k < 3) ? 4'b0100 : 4'b0000);
        end
        evt = '0;

        // Blink on bit 7 across the prescaler wrap.
        mode = 8'h02; sel = 20'd7;
        for (int k = 0; k < 300; k++) begin
            step();
            chk("wrap", led, {3'b000, pbit(ecnt - 1, 7)});
        end

        // Exit pass, then later exits ignored.
        mode = 8'h00; exit_valid = 1'b1; exit_val = 32'd0;
        step();
        chk("pass_latch", exit_latched, 1'b1);
        exit_valid = 1'b0;
        step();
        chk("pass_led", led, 4'hF);
        exit_valid = 1'b1; exit_val = 32'd5;
        repeat (3) begin
            step();
            chk("pass_sticky_lat", exit_latched, 1'b1);
            chk("pass_sticky_led", led, 4'hF);
        end
        exit_valid = 1'b0;

        rst = 1'b1;
        #1;
        chk("async_led", led, 4'h0);
        chk("async_lat", exit_latched, 1'b0);
        do_reset();

        // Exit fail overrides all-on mode with the prescaler blink.
        mode = 8'h55; exit_valid = 1'b1; exit_val = 32'd1;
        step();
        chk("fail_latch", exit_latched, 1'b1);
        exit_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("fail_blink", led, {4{pbit(ecnt - 1, FB)}});
        end

        rst = 1'b1;
        #1;
        chk("async2_led", led, 4'h0);
        chk("async2_lat", exit_latched, 1'b0);

        // Exit pending during release captures on the first running cycle.
        mode = 8'h00; exit_valid = 1'b1; exit_val = 32'd0;
        repeat (5) step();
        release_rst();
        chk("rel_exit_pre", exit_latched, 1'b0);
        step();
        chk("rel_exit_lat", exit_latched, 1'b1);
        step();
        chk("rel_exit_led", led, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
